// File: rtl/io_map_pkg.sv
// rtl/io_map_pkg.sv - I/O window address map, timing defaults and seven-segment LUT
package io_map_pkg;

  localparam logic [7:0] ADDR_SWDATA = 8'h80;
  localparam logic [7:0] ADDR_SWSTAT = 8'h84;
  localparam logic [7:0] ADDR_DISP   = 8'h88;
  localparam logic [7:0] ADDR_DSTAT  = 8'h8C;

  localparam int DEB_CYCLES_DEF = 1_000_000;
  localparam int SCAN_DIV_DEF   = 100_000;

  // Segments {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, stability counter and rising-edge pulse
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          s1, s2, level;
  logic [CW-1:0] cnt;

  // Accepted level starts high so a button held through reset must be released
  // and pressed again before it produces a pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b1;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      pulse <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= s2;
        cnt   <= '0;
        pulse <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_display_switch_port.sv
// rtl/mmio_display_switch_port.sv - MMIO switch capture, display commit and 8-digit scanner
module mmio_display_switch_port
  import io_map_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int SCAN_DIV   = SCAN_DIV_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_we,
  input  logic        io_re,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        btnl,
  input  logic        btnr,
  input  logic [15:0] sw,
  output logic [7:0]  an,
  output logic [6:0]  a2g
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic        btnl_pulse, btnr_pulse;
  logic [15:0] sw_s1, sw_s2, sw_data;
  logic        sw_ready;
  logic [31:0] disp_pend, disp_shown;
  logic        disp_pend_valid;
  logic [2:0]  digit;
  logic [SW-1:0] scan_cnt;
  logic [7:0]  word_addr;

  assign word_addr = addr & 8'hFC;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btnl (
    .clk(clk), .reset(reset), .btn(btnl), .pulse(btnl_pulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btnr (
    .clk(clk), .reset(reset), .btn(btnr), .pulse(btnr_pulse)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      sw_data  <= '0;
      sw_ready <= 1'b0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      // A capture in the same cycle as a data read wins over the ready clear.
      if (btnl_pulse) begin
        sw_data  <= sw_s2;
        sw_ready <= 1'b1;
      end else if (io_re && word_addr == ADDR_SWDATA) begin
        sw_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_pend       <= '0;
      disp_pend_valid <= 1'b0;
      disp_shown      <= '0;
    end else begin
      if (btnr_pulse && disp_pend_valid)
        disp_shown <= disp_pend;
      if (io_we && word_addr == ADDR_DISP) begin
        disp_pend       <= wdata;
        disp_pend_valid <= 1'b1;
      end else if (btnr_pulse && disp_pend_valid) begin
        disp_pend_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (word_addr)
      ADDR_SWDATA: rdata = {16'b0, sw_data};
      ADDR_SWSTAT: rdata = {31'b0, sw_ready};
      ADDR_DISP:   rdata = disp_shown;
      ADDR_DSTAT:  rdata = {31'b0, disp_pend_valid};
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      digit    <= '0;
      an       <= 8'hFE;
      a2g      <= 7'b1000000;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        digit    <= digit + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an  <= ~(8'b1 << digit);
      a2g <= hex_seg(disp_shown[{digit, 2'b00} +: 4]);
    end
  end

endmodule

// File: tb/tb_mmio_display_switch_port.sv
// tb/tb_mmio_display_switch_port.sv - directed self-checking bench for mmio_display_switch_port
module tb_mmio_display_switch_port;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        io_we = 1'b0;
  logic        io_re = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        btnl = 1'b0;
  logic        btnr = 1'b0;
  logic [15:0] sw = '0;
  logic [7:0]  an;
  logic [6:0]  a2g;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mmio_display_switch_port #(.DEB_CYCLES(4), .SCAN_DIV(3)) dut (
    .clk(clk), .reset(reset), .io_we(io_we), .io_re(io_re), .addr(addr),
    .wdata(wdata), .rdata(rdata), .btnl(btnl), .btnr(btnr), .sw(sw),
    .an(an), .a2g(a2g)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    io_re = 1'b1;
    addr  = a;
    #1;
    chk(tag, rdata, exp);
    @(posedge clk);
    #1;
    io_re = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    io_we = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    io_we = 1'b0;
  endtask

  task automatic press_l();
    @(negedge clk); btnl = 1'b1;
    repeat (10) @(negedge clk);
    btnl = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_r();
    @(negedge clk); btnr = 1'b1;
    repeat (10) @(negedge clk);
    btnr = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_an(input logic [7:0] v, input string tag);
    int k;
    k = 0;
    while (an !== v && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {24'b0, an}, {24'b0, v});
  endtask

  logic [7:0] an_exp  [8] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
  logic [6:0] seg_exp [8] = '{7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h00};

  initial begin
    // reset, let the scanner run, then reset again mid-scan
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_an", {24'b0, an}, 32'h0000_00FE);
    chk("rst_a2g", {25'b0, a2g}, 32'h0000_0040);
    addr = 8'h80; #1; chk("rst_swdata", rdata, 32'h0);
    addr = 8'h84; #1; chk("rst_swstat", rdata, 32'h0);
    addr = 8'h88; #1; chk("rst_disp", rdata, 32'h0);
    addr = 8'h8C; #1; chk("rst_dstat", rdata, 32'h0);
    // button held through reset release must not capture
    btnl = 1'b1;
    sw   = 16'hBEEF;
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    rd(8'h84, 32'h0, "held_no_capture");
    btnl = 1'b0;
    repeat (10) @(negedge clk);

    // bounce shorter than the debounce window
    btnl = 1'b1; repeat (2) @(negedge clk); btnl = 1'b0;
    repeat (10) @(negedge clk);
    rd(8'h84, 32'h0, "bounce_no_capture");
    @(negedge clk); btnl = 1'b1; @(negedge clk); btnl = 1'b0; @(negedge clk); btnl = 1'b1;
    repeat (10) @(negedge clk);
    btnl = 1'b0;
    repeat (10) @(negedge clk);
    rd(8'h84, 32'h1, "swstat_set");
    rd(8'h84, 32'h1, "swstat_read_no_clear");
    rd(8'h80, 32'h0000BEEF, "swdata");
    rd(8'h84, 32'h0, "swstat_cleared");

    // store then commit
    wr(8'h88, 32'h12345678);
    rd(8'h8C, 32'h1, "dstat_pending");
    rd(8'h88, 32'h0, "disp_not_yet");
    chk("a2g_still_0", {25'b0, a2g}, 32'h40);
    press_r();
    rd(8'h8C, 32'h0, "dstat_committed");
    rd(8'h88, 32'h12345678, "disp_shown");
    wait_an(8'hFE, "wait_digit0");
    chk("digit0_seg8", {25'b0, a2g}, 32'h00);

    // scan sequence over one full rotation
    wait_an(8'hFD, "wait_digit1");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("scan_an%0d", i), {24'b0, an}, {24'b0, an_exp[i]});
      chk($sformatf("scan_seg%0d", i), {25'b0, a2g}, {25'b0, seg_exp[i]});
      repeat (3) @(negedge clk);
    end

    // store coinciding with btnr pulse
    wr(8'h88, 32'h11111111);
    @(negedge clk); btnr = 1'b1;
    repeat (6) @(negedge clk);
    io_we = 1'b1; addr = 8'h88; wdata = 32'hAAAA0000;
    @(posedge clk); #1; io_we = 1'b0;
    repeat (4) @(negedge clk);
    btnr = 1'b0;
    repeat (10) @(negedge clk);
    rd(8'h88, 32'h11111111, "same_cycle_shown");
    rd(8'h8C, 32'h1, "same_cycle_dstat");
    press_r();
    rd(8'h88, 32'hAAAA0000, "pending_kept");
    rd(8'h8C, 32'h0, "dstat_after_commit");
    press_r();
    rd(8'h88, 32'hAAAA0000, "btnr_no_pending");

    // data read coinciding with btnl pulse
    sw = 16'h1234;
    press_l();
    rd(8'h80, 32'h00001234, "sw_recapture");
    rd(8'h84, 32'h0, "swstat_clear2");
    sw = 16'h5A5A;
    repeat (3) @(negedge clk);
    btnl = 1'b1;
    repeat (6) @(negedge clk);
    io_re = 1'b1; addr = 8'h80; #1;
    chk("same_cycle_old_data", rdata, 32'h00001234);
    @(posedge clk); #1; io_re = 1'b0;
    repeat (4) @(negedge clk);
    btnl = 1'b0;
    rd(8'h84, 32'h1, "same_cycle_ready_kept");
    rd(8'h80, 32'h00005A5A, "same_cycle_new_data");

    // unmapped store and read
    wr(8'h90, 32'hFFFFFFFF);
    rd(8'h88, 32'hAAAA0000, "unmapped_disp");
    rd(8'h8C, 32'h0, "unmapped_dstat");
    rd(8'h84, 32'h0, "unmapped_swstat");
    rd(8'h90, 32'h0, "unmapped_read");
    rd(8'h8B, 32'hAAAA0000, "byte_offset_ignored");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
